seven_seg_scan_ctrl: RTL and testbench

Controller that sequences the binary-to-display path of the seven-segment board top.
- Schedules a multi-cycle double-dabble binary-to-BCD conversion of the 8-bit switch value.
- Latches a consistent digit set.
- Time-multiplexes three common-anode/cathode digits, with leading-zero blanking and a ghosting guard.
- Sits between the registered switch inputs and the segment/digit pins.

---
 rtl/seven_seg_scan_ctrl_if.sv | 21 ++
 rtl/seven_seg_scan_ctrl.sv | 161 ++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_ctrl_if.sv
// Switch-value inputs and segment/digit pin outputs of the seven-segment scan controller.
// master = value source / pin consumer, slave = controller.
interface seven_seg_scan_ctrl_if;
    logic [7:0] value;
    logic       hex_mode;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] digit_en;
    logic       busy;
    logic       conv_done;

    modport master (
        output value, hex_mode,
        input  seg, dp, digit_en, busy, conv_done
    );

    modport slave (
        input  value, hex_mode,
        output seg, dp, digit_en, busy, conv_done
    );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Double-dabble binary-to-BCD sequencer plus three-digit multiplexed scan with
// leading-zero blanking and a dark window at the start of every digit slot.
module seven_seg_scan_ctrl #(
    parameter int SCAN_DIV       = 12000,   // >= 4
    parameter int BLANK_CYCLES   = 16,      // < SCAN_DIV
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input logic                  clk,
    input logic                  rst_n,
    seven_seg_scan_ctrl_if.slave bus
);
    localparam int         DW      = $clog2(SCAN_DIV);
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [2:0] DIG_OFF = DIG_ACTIVE_LOW ? 3'b111 : 3'b000;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state;
    logic [7:0]  value_q, last_value;
    logic        mode_q, last_mode;
    logic [19:0] sr, sr_adj;
    logic [2:0]  cnt;
    logic [3:0]  d_ones, d_tens, d_hund;
    logic        disp_hex;
    logic        busy_r, done_r;

    logic [DW-1:0] div;
    logic [1:0]    idx;
    logic [6:0]    seg_r;
    logic          dp_r;
    logic [2:0]    en_r;

    logic [3:0] cur_dig;
    logic       cur_blank;
    logic [6:0] cur_seg;
    logic [2:0] cur_en;
    logic       cur_dp;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        case (d)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    always_comb begin
        sr_adj        = sr;
        sr_adj[19:16] = add3(sr[19:16]);
        sr_adj[15:12] = add3(sr[15:12]);
        sr_adj[11:8]  = add3(sr[11:8]);
    end

    // Conversion sequencer; display digits move only in DONE so partial BCD never shows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            value_q    <= '0;
            mode_q     <= 1'b0;
            last_value <= '0;
            last_mode  <= 1'b0;
            sr         <= '0;
            cnt        <= '0;
            d_ones     <= '0;
            d_tens     <= '0;
            d_hund     <= '0;
            disp_hex   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            value_q <= bus.value;
            mode_q  <= bus.hex_mode;
            done_r  <= 1'b0;
            case (state)
                IDLE: begin
                    if ({value_q, mode_q} != {last_value, last_mode}) begin
                        last_value <= value_q;
                        last_mode  <= mode_q;
                        busy_r     <= 1'b1;
                        if (mode_q) begin
                            // hex nibbles parked where the BCD result would land
                            sr    <= {4'h0, value_q, 8'h00};
                            state <= DONE;
                        end else begin
                            sr    <= {12'h000, value_q};
                            cnt   <= '0;
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    sr  <= {sr_adj[18:0], 1'b0};
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) state <= DONE;
                end
                DONE: begin
                    d_hund   <= sr[19:16];
                    d_tens   <= sr[15:12];
                    d_ones   <= sr[11:8];
                    disp_hex <= last_mode;
                    done_r   <= 1'b1;
                    busy_r   <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        cur_dig   = d_ones;
        cur_blank = 1'b0;
        case (idx)
            2'd1: begin
                cur_dig   = d_tens;
                cur_blank = !disp_hex && (d_hund == 4'd0) && (d_tens == 4'd0);
            end
            2'd2: begin
                cur_dig   = d_hund;
                cur_blank = disp_hex || (d_hund == 4'd0);
            end
            default: ;
        endcase
        cur_seg = seg_enc(cur_dig);
        cur_dp  = disp_hex && (idx == 2'd0);
        cur_en  = (cur_blank || (div < DW'(BLANK_CYCLES))) ? 3'b000 : (3'b001 << idx);
    end

    // Free-running slot timer; seg and digit_en are both registered so they switch together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div   <= '0;
            idx   <= 2'd0;
            seg_r <= SEG_OFF;
            dp_r  <= SEG_ACTIVE_LOW;
            en_r  <= DIG_OFF;
        end else begin
            if (div == DW'(SCAN_DIV - 1)) begin
                div <= '0;
                idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            end else begin
                div <= div + 1'b1;
            end
            seg_r <= SEG_ACTIVE_LOW ? ~cur_seg : cur_seg;
            dp_r  <= SEG_ACTIVE_LOW ? ~cur_dp : cur_dp;
            en_r  <= DIG_ACTIVE_LOW ? ~cur_en : cur_en;
        end
    end

    assign bus.seg       = seg_r;
    assign bus.dp        = dp_r;
    assign bus.digit_en  = en_r;
    assign bus.busy      = busy_r;
    assign bus.conv_done = done_r;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl: scoreboard of expected digit sets,
// latency/busy checks, full scan-rotation capture and async-reset checks.
module tb_seven_seg_scan_ctrl;
    localparam int SD = 8;
    localparam int BC = 2;
    localparam logic [6:0] SEGTAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct packed {
        logic [6:0] sh, st, so;
        logic       eh, et, eo, dp;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passed = 0;
    exp_t sb[$];
    logic watch5 = 1'b0;
    int   w5bad = 0;

    seven_seg_scan_ctrl_if bus();

    seven_seg_scan_ctrl #(
        .SCAN_DIV(SD), .BLANK_CYCLES(BC), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] lseg(input int d);
        return ~SEGTAB[d];
    endfunction

    function automatic exp_t mk(input int v, input bit hex);
        exp_t e;
        int h, t, o;
        if (hex) begin
            h = 0; t = v / 16; o = v % 16;
            e.eh = 1'b0; e.et = 1'b1; e.eo = 1'b1; e.dp = 1'b0;
        end else begin
            h = v / 100; t = (v / 10) % 10; o = v % 10;
            e.eh = (h != 0); e.et = (h != 0) || (t != 0); e.eo = 1'b1; e.dp = 1'b1;
        end
        e.sh = lseg(h); e.st = lseg(t); e.so = lseg(o);
        return e;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic drive(input int v, input bit hex, input bit push);
        @(negedge clk);
        bus.value    = 8'(v);
        bus.hex_mode = hex;
        if (push) sb.push_back(mk(v, hex));
    endtask

    // Counts posedges from the call until conv_done is seen; optionally changes value mid-flight.
    task automatic run_conv(input string tag, input int edges, input int chg_n, input int chg_v,
                            output int bc, output exp_t e);
        int  n = 0;
        bit  seen = 0;
        bc = 0;
        e  = '0;
        while (!seen && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (bus.busy) bc++;
            if (bus.conv_done) seen = 1;
            if (n == chg_n) begin
                bus.value = 8'(chg_v);
                sb.push_back(mk(chg_v, 1'b0));
            end
        end
        chk({tag, "_latency"}, n, edges);
        if (sb.size() > 0) e = sb.pop_front();
        else chk({tag, "_sb_empty"}, 1, 0);
    endtask

    // One full 3-slot rotation; every lit digit must match the popped expectation.
    task automatic scan(input string tag, input exp_t e);
        int         c[3] = '{0, 0, 0};
        logic [6:0] s[3] = '{7'h00, 7'h00, 7'h00};
        logic       dpo = 1'b0;
        int         dark = 0, bad = 0, ordbad = 0, prev = -1, slot;
        logic [2:0] en;
        int         nlit;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3 * SD; i++) begin
            @(negedge clk);
            en   = ~bus.digit_en;
            slot = -1;
            case (en)
                3'b000: dark++;
                3'b001: begin c[0]++; s[0] = bus.seg; dpo = bus.dp; slot = 0; end
                3'b010: begin c[1]++; s[1] = bus.seg; slot = 1; end
                3'b100: begin c[2]++; s[2] = bus.seg; slot = 2; end
                default: bad++;
            endcase
            if (slot >= 0 && prev >= 0 && slot != prev && slot != (prev + 1) % 3) ordbad++;
            if (slot >= 0) prev = slot;
        end
        nlit = int'(e.eh) + int'(e.et) + int'(e.eo);
        chk({tag, "_multi_en"}, bad, 0);
        chk({tag, "_cnt_h"}, c[2], e.eh ? SD - BC : 0);
        chk({tag, "_cnt_t"}, c[1], e.et ? SD - BC : 0);
        chk({tag, "_cnt_o"}, c[0], e.eo ? SD - BC : 0);
        chk({tag, "_dark"}, dark, 3 * SD - nlit * (SD - BC));
        if (e.eh) chk({tag, "_seg_h"}, s[2], e.sh);
        if (e.et) chk({tag, "_seg_t"}, s[1], e.st);
        chk({tag, "_seg_o"}, s[0], e.so);
        chk({tag, "_dp"}, dpo, e.dp);
        if (nlit == 3) chk({tag, "_order"}, ordbad, 0);
    endtask

    // During the 45->99 sequence only digits of 0, 45 or 99 may appear.
    always @(negedge clk) begin
        if (watch5 && rst_n) begin
            if (!bus.digit_en[2]) w5bad++;
            if (!bus.digit_en[1] && bus.seg != lseg(4) && bus.seg != lseg(9)) w5bad++;
            if (!bus.digit_en[0] && bus.seg != lseg(0) && bus.seg != lseg(5) && bus.seg != lseg(9)) w5bad++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   bc, bad, segbad, cd;
        exp_t e;
        bus.value    = 8'd0;
        bus.hex_mode = 1'b0;
        rst_n        = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_seg", bus.seg, 7'h7F);
        chk("rst_dp", bus.dp, 1);
        chk("rst_digit_en", bus.digit_en, 3'b111);
        chk("rst_busy", bus.busy, 0);
        chk("rst_conv_done", bus.conv_done, 0);
        rst_n = 1'b1;

        // idle with value 0: only the ones digit, showing 0, no conversion
        bad = 0; segbad = 0; cd = 0;
        for (int i = 0; i < 9 * SD; i++) begin
            @(negedge clk);
            if (bus.digit_en[2:1] != 2'b11) bad++;
            if (!bus.digit_en[0] && bus.seg != 7'b1000000) segbad++;
            if (bus.conv_done) cd++;
        end
        chk("idle_only_ones", bad, 0);
        chk("idle_seg_zero", segbad, 0);
        chk("idle_no_conv", cd, 0);

        // 255 decimal: latency, busy length, all three digits lit in order
        drive(255, 1'b0, 1'b1);
        run_conv("d255", 11, 0, 0, bc, e);
        chk("d255_busy", bc, 9);
        scan("d255", e);

        drive(35, 1'b0, 1'b1);
        run_conv("d35", 11, 0, 0, bc, e);
        scan("d35", e);

        drive(100, 1'b0, 1'b1);
        run_conv("d100", 11, 0, 0, bc, e);
        scan("d100", e);

        // hex D2
        drive(210, 1'b1, 1'b1);
        run_conv("h210", 3, 0, 0, bc, e);
        chk("h210_busy", bc, 1);
        scan("h210", e);

        // back to decimal 0, then 45 changed to 99 mid-shift
        drive(0, 1'b0, 1'b1);
        run_conv("d0", 11, 0, 0, bc, e);
        scan("d0", e);
        watch5 = 1'b1;
        drive(45, 1'b0, 1'b1);
        run_conv("d45", 11, 5, 99, bc, e);
        run_conv("d99", 10, 0, 0, bc, e);
        scan("d99", e);
        watch5 = 1'b0;
        chk("d45_99_no_stray", w5bad, 0);

        // async reset mid-SHIFT
        drive(77, 1'b0, 1'b0);
        repeat (3) begin @(posedge clk); @(negedge clk); end
        chk("pre_rst_busy", bus.busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_seg", bus.seg, 7'h7F);
        chk("arst_digit_en", bus.digit_en, 3'b111);
        chk("arst_busy", bus.busy, 0);
        chk("arst_dp", bus.dp, 1);
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(mk(77, 1'b0));
        run_conv("d77", 11, 0, 0, bc, e);
        scan("d77", e);

        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
